ws2812b_stream_tx: RTL
======================

# ws2812b_stream_tx

Parametrised WS2812B serial LED driver fed by a valid/ready pixel stream. It generalises the fixed 64-LED, fixed-pattern driver: LED count, bit timings, colour order and global brightness are configurable, and frames are started on demand. A one-pixel holding buffer keeps the symbol stream gap-free, and underruns are detected. It sits between a pixel source (pattern generator, framebuffer reader) and a single GPIO pin.

## Interface
- NLEDS, 64: LEDs per frame; must be ≥1.
- T0H, 18: '0' symbol high time, in clock cycles.
- T0L, 40: '0' symbol low time, in cycles.
- T1H, 35: '1' symbol high time, in cycles.
- T1L, 30: '1' symbol low time, in cycles.
- TRESET, 3000: latch low time after the last bit, in cycles.
- UNDERRUN_CYC, 1500: maximum extra low cycles allowed while waiting for a pixel.
- ORDER, 0: wire order. 0 = GRB, 1 = RGB.
- All timing parameters are ≥1.
- CLOCK_50  in  1  sole clock; all logic is on the rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  one-cycle frame request. Honoured only when busy=0.
- bright  in  8  global brightness, sampled on the cycle start is accepted.
- pix_data  in  24  pixel as {R,G,B}.
- pix_valid  in  1  pix_data is valid.
- pix_ready  out  1  the holding buffer accepts a pixel this cycle.
- dout  out  1  serial line to the LED strip (registered).
- busy  out  1  a frame is in progress, including the latch period.
- done  out  1  one-cycle pulse at the end of the latch period.
- underrun  out  1  one-cycle pulse when a frame is aborted for lack of data.

## Operation
- States: IDLE, WAIT, HIGH, LOW, LATCH.
- IDLE: dout=0, busy=0.
  - start=1 latches bright, clears the pixel counters and enters WAIT.
- Holding buffer:
  - pix_ready = busy & buffer empty & (pixels accepted < NLEDS).
  - A transfer occurs when pix_valid & pix_ready on the same cycle.
  - The transfer fills the buffer in that cycle.
- Load:
  - Entering HIGH from WAIT, or from LOW after bit 0, moves the buffer into a 24-bit shift register and empties the buffer.
  - Per-channel scaling: c' = (c × (bright+1)) >> 8, computed as 16-bit intermediates truncated to 8 bits.
  - The shift register holds {G',R',B'} when ORDER=0 and {R',G',B'} when ORDER=1.
  - Bits are sent MSB first.
- HIGH: dout=1 for exactly T1H cycles (bit=1) or T0H cycles (bit=0), then go to LOW.
- LOW: dout=0 for exactly T1L or T0L cycles. At the end of the period:
  - bit index ≠ 0: shift, decrement the index, go to HIGH.
  - bit index = 0 and pixels sent < NLEDS, buffer full: load and go to HIGH with no gap.
  - bit index = 0 and pixels sent < NLEDS, buffer empty: go to WAIT.
  - bit index = 0 and pixels sent = NLEDS: go to LATCH.
- WAIT: dout=0 and a stall counter increments.
  - Buffer becomes full: load and go to HIGH.
  - Stall counter reaches UNDERRUN_CYC: pulse underrun, drop the rest of the frame, go to LATCH.
  - The first pixel of a frame never counts as an underrun; that wait is unbounded.
- LATCH: dout=0 for TRESET cycles, then pulse done and enter IDLE.
  - pix_ready=0 throughout.
- Counter widths: $clog2 of the largest value held (NLEDS, max timing parameter, UNDERRUN_CYC), plus 1.

## Timing
- Reset values: dout=0, busy=0, done=0, underrun=0, pix_ready=0. State is IDLE and the buffer is empty.
- Reset mid-frame: dout is 0 on the next edge. The frame is abandoned without a latch or done pulse.
- start accepted at cycle N: busy=1 and pix_ready=1 at N+1.
- Pixel transfer at cycle M while in WAIT: dout=1 at M+1.
- Frame length with no stalls, for a start pulse followed by a first transfer at F: Σ(symbol times) + TRESET.
  - done is high at F+1+that length.
  - busy falls in the same cycle as done.
- start while busy=1 is ignored; no queueing.
- start in the same cycle that done pulses is ignored. A new start is accepted from the following cycle.
- pix_valid may be held high. Once the frame's NLEDS pixels have been accepted, no further pixel is accepted.

## Structure
- Package ws2812b_pkg holds:
  - the state enum;
  - ORDER_GRB=0 and ORDER_RGB=1;
  - the default timing constants for a 50 MHz clock.
- Sub-module ws2812b_symbol_timer:
  - loads a duration and a level;
  - counts down;
  - asserts last on the final cycle.
  - It is reused for the HIGH, LOW and LATCH periods.
- The top FSM owns the holding buffer, the scaler, the shift register and the pixel/bit counters.

## Test plan
- Basic frame:
  - Configuration: NLEDS=2, T0H=2, T0L=4, T1H=4, T1L=2, TRESET=10, UNDERRUN_CYC=20, bright=255, ORDER=0.
  - Stimulus: pixels 0xFF0000 then 0x000001.
  - Required: 48 symbols decode to 0x00FF00 then 0x000001, every symbol period is exactly 6 cycles, then 10 low cycles, then done.
- Brightness: bright=127, pixel 0xFF8040 → wire bytes G=0x40, R=0x7F, B=0x20. bright=0 → all 24 bits are '0'.
- Underrun: withhold the second pixel. Required:
  - dout stays low for 20 cycles past T0L;
  - underrun pulses once;
  - then TRESET low cycles, then done;
  - pix_ready=0 during LATCH.
- Reset mid-HIGH: dout=0, busy=0 and pix_ready=0 on the next edge. A following start sends a full, correct frame.
- Arbitration: start pulses while busy are ignored. start on the cycle after done runs a back-to-back frame with a correct bit stream.
- ORDER=1, pixel 0x123456 → wire bytes 0x12, 0x34, 0x56 in that order.

Source files
------------

// File: rtl/ws2812b_pkg.sv
// Shared types and constants for the WS2812B stream transmitter.
// Default timings assume a 50 MHz clock (20 ns per cycle).
package ws2812b_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WAIT,
    HIGH,
    LOW,
    LATCH
  } state_t;

  localparam int ORDER_GRB = 0;
  localparam int ORDER_RGB = 1;

  localparam int DEF_T0H          = 18;
  localparam int DEF_T0L          = 40;
  localparam int DEF_T1H          = 35;
  localparam int DEF_T1L          = 30;
  localparam int DEF_TRESET       = 3000;
  localparam int DEF_UNDERRUN_CYC = 1500;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/ws2812b_symbol_timer.sv
// Loadable down-counter that holds the line level for a fixed number of cycles;
// last is high on the final cycle of the loaded duration.
module ws2812b_symbol_timer
  import ws2812b_pkg::*;
#(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] dur,
  input  logic         level,
  output logic         out,
  output logic         last
);

  logic [W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt <= '0;
      out <= 1'b0;
    end else if (load) begin
      cnt <= dur - 1'b1;
      out <= level;
    end else if (cnt != '0) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign last = (cnt == '0);

endmodule

// File: rtl/ws2812b_stream_tx.sv
// WS2812B driver fed by a valid/ready pixel stream, with a one-pixel holding
// buffer, global brightness scaling, selectable colour order and underrun abort.
module ws2812b_stream_tx
  import ws2812b_pkg::*;
#(
  parameter int NLEDS        = 64,
  parameter int T0H          = DEF_T0H,
  parameter int T0L          = DEF_T0L,
  parameter int T1H          = DEF_T1H,
  parameter int T1L          = DEF_T1L,
  parameter int TRESET       = DEF_TRESET,
  parameter int UNDERRUN_CYC = DEF_UNDERRUN_CYC,
  parameter int ORDER        = ORDER_GRB
) (
  input  logic        CLOCK_50,
  input  logic        reset,
  input  logic        start,
  input  logic [7:0]  bright,
  input  logic [23:0] pix_data,
  input  logic        pix_valid,
  output logic        pix_ready,
  output logic        dout,
  output logic        busy,
  output logic        done,
  output logic        underrun
);

  localparam int MAXT = max_int(max_int(max_int(T0H, T0L), max_int(T1H, T1L)), TRESET);
  localparam int MAXV = max_int(max_int(NLEDS, UNDERRUN_CYC), MAXT);
  localparam int CW   = $clog2(MAXV) + 1;
  localparam logic [CW-1:0] NLEDS_C    = CW'(NLEDS);
  localparam logic [CW-1:0] STALL_LAST = CW'(UNDERRUN_CYC - 1);

  state_t        state, next_state;
  logic [7:0]    bright_q;
  logic [23:0]   buf_data, shreg, pix_src, load_word;
  logic [7:0]    r_s, g_s, b_s;
  logic          buf_full, xfer, avail;
  logic [4:0]    bit_idx;
  logic [CW-1:0] acc_cnt, sent_cnt, stall_cnt;
  logic          accept_start, do_load, do_shift, done_set, underrun_set;
  logic          tmr_load, tmr_lvl, tmr_last;
  logic [CW-1:0] tmr_dur;

  // (c * (bright+1)) >> 8 keeps full scale at bright=255 and zero at bright=0.
  function automatic logic [7:0] scale(input logic [7:0] c, input logic [7:0] b);
    logic [15:0] prod;
    prod = {8'd0, c} * ({8'd0, b} + 16'd1);
    return prod[15:8];
  endfunction

  function automatic logic [CW-1:0] high_dur(input logic b);
    return b ? CW'(T1H) : CW'(T0H);
  endfunction

  function automatic logic [CW-1:0] low_dur(input logic b);
    return b ? CW'(T1L) : CW'(T0L);
  endfunction

  assign busy      = (state != IDLE);
  assign pix_ready = busy && (state != LATCH) && !buf_full && (acc_cnt < NLEDS_C);
  assign xfer      = pix_valid && pix_ready;
  // A pixel arriving this cycle is usable at once, so a load never waits on the buffer register.
  assign avail     = buf_full || xfer;
  assign pix_src   = buf_full ? buf_data : pix_data;

  assign r_s       = scale(pix_src[23:16], bright_q);
  assign g_s       = scale(pix_src[15:8],  bright_q);
  assign b_s       = scale(pix_src[7:0],   bright_q);
  assign load_word = (ORDER == ORDER_RGB) ? {r_s, g_s, b_s} : {g_s, r_s, b_s};

  always_ff @(posedge CLOCK_50) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state   = state;
    accept_start = 1'b0;
    do_load      = 1'b0;
    do_shift     = 1'b0;
    done_set     = 1'b0;
    underrun_set = 1'b0;
    tmr_load     = 1'b0;
    tmr_lvl      = 1'b0;
    tmr_dur      = '0;
    unique case (state)
      IDLE: begin
        if (start && !done) begin
          accept_start = 1'b1;
          next_state   = WAIT;
        end
      end
      WAIT: begin
        if (avail) begin
          do_load    = 1'b1;
          tmr_load   = 1'b1;
          tmr_lvl    = 1'b1;
          tmr_dur    = high_dur(load_word[23]);
          next_state = HIGH;
        end else if (sent_cnt != '0 && stall_cnt == STALL_LAST) begin
          underrun_set = 1'b1;
          tmr_load     = 1'b1;
          tmr_dur      = CW'(TRESET);
          next_state   = LATCH;
        end
      end
      HIGH: begin
        if (tmr_last) begin
          tmr_load   = 1'b1;
          tmr_dur    = low_dur(shreg[23]);
          next_state = LOW;
        end
      end
      LOW: begin
        if (tmr_last) begin
          if (bit_idx != 5'd0) begin
            do_shift   = 1'b1;
            tmr_load   = 1'b1;
            tmr_lvl    = 1'b1;
            tmr_dur    = high_dur(shreg[22]);
            next_state = HIGH;
          end else if (sent_cnt == NLEDS_C) begin
            tmr_load   = 1'b1;
            tmr_dur    = CW'(TRESET);
            next_state = LATCH;
          end else if (avail) begin
            do_load    = 1'b1;
            tmr_load   = 1'b1;
            tmr_lvl    = 1'b1;
            tmr_dur    = high_dur(load_word[23]);
            next_state = HIGH;
          end else begin
            next_state = WAIT;
          end
        end
      end
      LATCH: begin
        if (tmr_last) begin
          done_set   = 1'b1;
          next_state = IDLE;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      buf_full  <= 1'b0;
      acc_cnt   <= '0;
      sent_cnt  <= '0;
      stall_cnt <= '0;
      bit_idx   <= '0;
      done      <= 1'b0;
      underrun  <= 1'b0;
    end else begin
      done      <= done_set;
      underrun  <= underrun_set;
      stall_cnt <= (state == WAIT) ? stall_cnt + 1'b1 : '0;
      if (accept_start) begin
        buf_full <= 1'b0;
        acc_cnt  <= '0;
        sent_cnt <= '0;
      end else begin
        if (do_load)   buf_full <= 1'b0;
        else if (xfer) buf_full <= 1'b1;
        if (xfer)    acc_cnt  <= acc_cnt + 1'b1;
        if (do_load) sent_cnt <= sent_cnt + 1'b1;
      end
      if (do_load)       bit_idx <= 5'd23;
      else if (do_shift) bit_idx <= bit_idx - 5'd1;
    end
  end

  always_ff @(posedge CLOCK_50) begin
    if (accept_start) bright_q <= bright;
    if (xfer)         buf_data <= pix_data;
    if (do_load)       shreg <= load_word;
    else if (do_shift) shreg <= {shreg[22:0], 1'b0};
  end

  ws2812b_symbol_timer #(.W(CW)) u_timer (
    .clk   (CLOCK_50),
    .reset (reset),
    .load  (tmr_load),
    .dur   (tmr_dur),
    .level (tmr_lvl),
    .out   (dout),
    .last  (tmr_last)
  );

endmodule
